alu_result_fifo: RTL and testbench

Downstream buffering stage for the registered 9-bit signed ALU result. Captures one result per cycle when the producer flags it valid, stores it with its opcode in a FIFO, and presents entries to the consumer through a valid/ready handshake. It decouples the free-running ALU output register from a consumer that can stall. An optional saturating accumulator sums results as they leave.

---
 rtl/alu_result_fifo.sv | 126 ++++++++++++
 tb/tb_alu_result_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// Result buffer between the registered ALU output and a stallable consumer.
// Optional accumulator over popped results, built only when ALU_FIFO_ACC_EN is defined.
module alu_result_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [2:0]    in_opcode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_opcode,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          drop_err,
    output logic [15:0]   acc,
    output logic          acc_sat
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Handshake: the producer side has no backpressure, so in_valid is a
    // one-cycle strobe; the consumer side transfers the head on any edge where
    // out_valid && out_ready, and out_valid never depends on out_ready.
    logic [DW+2:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          drop_q;
    logic          push;
    logic          pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;
    assign out_valid = !empty;
    assign drop_err  = drop_q;

    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);

    assign out_data   = mem[rd_ptr][DW-1:0];
    assign out_opcode = mem[rd_ptr][DW+2:DW];

    // Storage carries no reset; only pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= {in_opcode, in_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (in_valid && !push) begin
                drop_q <= 1'b1;
            end
        end
    end

`ifdef ALU_FIFO_ACC_EN
    logic [15:0] acc_q;
    logic        sat_q;
    logic [16:0] acc_sum;
    logic [15:0] acc_next;
    logic        acc_clamp;

    // 17-bit sum of two sign-extended operands; bits 16 and 15 disagree on overflow.
    always_comb begin
        acc_sum   = {acc_q[15], acc_q} + {{(17 - DW){out_data[DW-1]}}, out_data};
        acc_clamp = (acc_sum[16] != acc_sum[15]);
        acc_next  = acc_sum[15:0];
        if (acc_clamp) begin
            acc_next = acc_sum[16] ? 16'h8000 : 16'h7fff;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (clr) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (pop) begin
            acc_q <= acc_next;
            if (acc_clamp) begin
                sat_q <= 1'b1;
            end
        end
    end

    assign acc     = acc_q;
    assign acc_sat = sat_q;
`else
    assign acc     = '0;
    assign acc_sat = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: reset, ordering across wrap, full/drop,
// throughput, clr priority and the accumulator (expected zero when not built).
module tb_alu_result_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 9;

    // clock / reset
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [2:0]    in_opcode = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [2:0]    out_opcode;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic          drop_err;
    logic [15:0]   acc;
    logic          acc_sat;

    alu_result_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_data(in_data), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_opcode(out_opcode),
        .count(count), .full(full), .empty(empty),
        .drop_err(drop_err), .acc(acc), .acc_sat(acc_sat)
    );

    // scoreboard
    logic [11:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int m_count = 0;
    logic m_drop = 1'b0;
    int m_acc = 0;
    logic m_sat = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0;
        m_drop = 1'b0;
        m_acc = 0;
        m_sat = 1'b0;
    endtask

    // One clock: check outputs against the model, advance the model, take the edge.
    task automatic tick();
        logic pop_m;
        logic signed [DW-1:0] d;
        int s;
        pop_m = (m_count > 0) && out_ready;
        chk("out_valid", 32'(out_valid), 32'(m_count > 0));
        chk("count", 32'(count), 32'(m_count));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
        chk("acc", 32'(acc), 32'(16'(m_acc)));
        chk("acc_sat", 32'(acc_sat), 32'(m_sat));
        if (clr) begin
            model_reset();
        end else begin
            if (pop_m) begin
                chk("head", 32'({out_opcode, out_data}), 32'(exp_q[0]));
                d = exp_q[0][DW-1:0];
`ifdef ALU_FIFO_ACC_EN
                s = m_acc + int'(d);
                if (s > 32767) begin
                    s = 32767;
                    m_sat = 1'b1;
                end else if (s < -32768) begin
                    s = -32768;
                    m_sat = 1'b1;
                end
                m_acc = s;
`else
                s = int'(d);
`endif
                void'(exp_q.pop_front());
            end
            if (in_valid && (m_count < DEPTH || pop_m)) begin
                exp_q.push_back({in_opcode, in_data});
            end else if (in_valid) begin
                m_drop = 1'b1;
            end
            m_count = exp_q.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [DW-1:0] d, input logic [2:0] op, input logic rdy);
        in_valid = 1'b1;
        in_data = d;
        in_opcode = op;
        out_ready = rdy;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        out_ready = 1'b0;
    endtask

    int vals[10] = '{-256, -1, 0, 1, 255, 7, -7, 100, 3, 4};

    initial begin
        // reset state
        #1 rstn = 1'b0;
        #10;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_acc_sat", 32'(acc_sat), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // async reset mid-stream
        push_one(9'd10, 3'd1, 1'b0);
        push_one(9'd11, 3'd2, 1'b0);
        push_one(9'd12, 3'd3, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        model_reset();
        #2 rstn = 1'b1;
        push_one(9'd5, 3'd4, 1'b0);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'd5);
        drain();

        // order across pointer wrap
        do_clr();
        for (int i = 0; i < 8; i++) push_one(vals[i][DW-1:0], 3'(i), 1'b0);
        chk("wrap_full", 32'(full), 32'd1);
        chk("wrap_count8", 32'(count), 32'd8);
        push_one(vals[8][DW-1:0], 3'd0, 1'b1);
        push_one(vals[9][DW-1:0], 3'd1, 1'b1);
        chk("wrap_count_still8", 32'(count), 32'd8);
        drain();
        chk("wrap_empty", 32'(empty), 32'd1);

        // full boundary: drop then accepted push with simultaneous pop
        do_clr();
        for (int i = 0; i < 8; i++) push_one(9'(i + 20), 3'd5, 1'b0);
        push_one(9'd42, 3'd6, 1'b0);
        chk("drop_err_set", 32'(drop_err), 32'd1);
        chk("drop_count", 32'(count), 32'd8);
        push_one(9'd42, 3'd7, 1'b1);
        chk("full_pop_push_count", 32'(count), 32'd8);
        chk("drop_err_sticky", 32'(drop_err), 32'd1);
        drain();

        // throughput
        do_clr();
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 9'(i * 3);
            in_opcode = 3'(i);
            tick();
        end
        chk("tp_count", 32'(count), 32'd1);
        chk("tp_valid", 32'(out_valid), 32'd1);
        drain();

        // clr priority over push and pop
        do_clr();
        for (int i = 0; i < 8; i++) push_one(9'(i), 3'd2, 1'b0);
        push_one(9'd99, 3'd2, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("clr_pre_count", 32'(count), 32'd5);
        chk("clr_pre_drop", 32'(drop_err), 32'd1);
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 9'd77;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_drop", 32'(drop_err), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        tick();

        // accumulator saturation: 129 pops of 255
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = 9'd255;
        in_opcode = 3'd0;
        for (int i = 0; i < 129; i++) tick();
        in_valid = 1'b0;
        tick();
`ifdef ALU_FIFO_ACC_EN
        chk("acc_sat_val", 32'(acc), 32'h7fff);
        chk("acc_sat_flag", 32'(acc_sat), 32'd1);
`else
        chk("acc_off_val", 32'(acc), 32'd0);
        chk("acc_off_flag", 32'(acc_sat), 32'd0);
`endif

        // accumulator restarts after clr
        do_clr();
        out_ready = 1'b1;
        push_one(9'h100, 3'd1, 1'b1);
        push_one(9'd100, 3'd2, 1'b1);
`ifdef ALU_FIFO_ACC_EN
        chk("acc_m256", 32'(acc), 32'hff00);
`else
        chk("acc_off_m256", 32'(acc), 32'd0);
`endif
        tick();
`ifdef ALU_FIFO_ACC_EN
        chk("acc_m156", 32'(acc), 32'hff64);
        chk("acc_m156_nosat", 32'(acc_sat), 32'd0);
`else
        chk("acc_off_m156", 32'(acc), 32'd0);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
